ca_dispatch: RTL and testbench

Consumer end of the calendar match interface. Accepts matched commands from `ca` over `ca_match`/`ca_command` and applies backpressure with `ca_match_block`. Buffers the commands in a small FIFO and executes them in order: it drives timed GPIO updates and issues thread wake requests to the thread pipeline. It sits between `ca` and the core's thread scheduler / port logic.

---
 rtl/ca_dispatch_pkg.sv | 27 ++
 rtl/ca_dispatch_if.sv | 9 +
 rtl/ca_dispatch_fifo.sv | 50 +++++
 rtl/ca_dispatch.sv | 146 ++++++++++++++
 tb/tb_ca_dispatch.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ca_dispatch_pkg.sv
// Shared definitions for the calendar-match dispatcher: opcodes, command word field
// positions and execution FSM state encodings.
package ca_dispatch_pkg;

  localparam logic [3:0] CA_OP_NOP  = 4'd0;
  localparam logic [3:0] CA_OP_WAKE = 4'd1;
  localparam logic [3:0] CA_OP_SET  = 4'd2;
  localparam logic [3:0] CA_OP_CLR  = 4'd3;
  localparam logic [3:0] CA_OP_TGL  = 4'd4;
  localparam logic [3:0] CA_OP_WR   = 4'd5;

  localparam int unsigned CA_OP_MSB  = 31;
  localparam int unsigned CA_OP_LSB  = 28;
  localparam int unsigned CA_TID_MSB = 27;
  localparam int unsigned CA_TID_LSB = 24;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWaitAck
  } ca_state_e;

  function automatic logic ca_op_legal(logic [3:0] op);
    return op <= CA_OP_WR;
  endfunction

endpackage

// File: rtl/ca_dispatch_if.sv
// Calendar match link between the ca producer (master) and ca_dispatch (slave).
interface ca_dispatch_if;
  logic        ca_match;
  logic [31:0] ca_command;
  logic        ca_match_block;

  modport master (output ca_match, output ca_command, input ca_match_block);
  modport slave  (input ca_match, input ca_command, output ca_match_block);
endinterface

// File: rtl/ca_dispatch_fifo.sv
// Synchronous command FIFO; push and pop in the same cycle both succeed, even when full.
module ca_dispatch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = count_q == CW'(Depth);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/ca_dispatch.sv
// Calendar match consumer: buffers matched commands and executes GPIO updates and thread wakes.
// Optional build macro CA_DISPATCH_STATS_EN enables the executed-command counter.
module ca_dispatch
  import ca_dispatch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GPIO_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  ca_dispatch_if.slave      ca,
  output logic              wake_req,
  output logic [3:0]        wake_tid,
  input  logic              wake_ack,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              cmd_err,
  output logic [15:0]       dispatch_count
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = GPIO_W + 8;

  ca_state_e         state_q, state_d;
  logic [EW-1:0]     cmd_q, cmd_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              wake_req_q, wake_req_d;
  logic [3:0]        wake_tid_q, wake_tid_d;
  logic              err_q, err_d;
  logic              block_q, block_d;

  logic              push, push_ok, pop, overflow;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, cnt_after;
  logic [EW-1:0]     fifo_wdata, fifo_rdata;
  logic [3:0]        op, tid;
  logic [GPIO_W-1:0] data;
  logic              unused_cmd;

  // Only opcode, tid and data travel through the FIFO.
  assign fifo_wdata = {ca.ca_command[CA_OP_MSB:CA_OP_LSB], ca.ca_command[CA_TID_MSB:CA_TID_LSB],
                       ca.ca_command[GPIO_W-1:0]};
  assign unused_cmd = ^ca.ca_command;

  // A strobe seen while block_q is high is a repeat of an already-seen command.
  assign push      = ca.ca_match & ~block_q;
  assign pop       = (state_q == StIdle) & ~fifo_empty;
  assign push_ok   = push & (~fifo_full | pop);
  assign overflow  = push & fifo_full & ~pop;
  assign cnt_after = fifo_count + CW'(push_ok) - CW'(pop);
  assign block_d   = cnt_after >= CW'(FIFO_DEPTH - 1);

  ca_dispatch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign op   = cmd_q[EW-1 -: 4];
  assign tid  = cmd_q[EW-5 -: 4];
  assign data = cmd_q[GPIO_W-1:0];

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    gpio_d     = gpio_q;
    wake_req_d = wake_req_q;
    wake_tid_d = wake_tid_q;
    err_d      = err_q | overflow;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cmd_d   = fifo_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StIdle;
        case (op)
          CA_OP_WAKE: begin
            wake_req_d = 1'b1;
            wake_tid_d = tid;
            state_d    = StWaitAck;
          end
          CA_OP_SET: gpio_d = gpio_q | data;
          CA_OP_CLR: gpio_d = gpio_q & ~data;
          CA_OP_TGL: gpio_d = gpio_q ^ data;
          CA_OP_WR:  gpio_d = data;
          default:   if (!ca_op_legal(op)) err_d = 1'b1;
        endcase
      end
      StWaitAck: begin
        if (wake_ack) begin
          wake_req_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      gpio_q     <= '0;
      wake_req_q <= 1'b0;
      wake_tid_q <= '0;
      err_q      <= 1'b0;
      block_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      gpio_q     <= gpio_d;
      wake_req_q <= wake_req_d;
      wake_tid_q <= wake_tid_d;
      err_q      <= err_d;
      block_q    <= block_d;
    end
  end

  assign ca.ca_match_block = block_q;
  assign wake_req          = wake_req_q;
  assign wake_tid          = wake_tid_q;
  assign gpio_out          = gpio_q;
  assign cmd_err           = err_q;

`ifdef CA_DISPATCH_STATS_EN
  logic [15:0] exec_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  exec_cnt_q <= '0;
    else if (state_q == StExec) exec_cnt_q <= exec_cnt_q + 16'd1;
  end
  assign dispatch_count = exec_cnt_q;
`else
  assign dispatch_count = '0;
`endif

endmodule

// File: tb/tb_ca_dispatch.sv
// Directed bench for ca_dispatch: latency, wake handshake, backpressure, sequencing, errors, reset.
module tb_ca_dispatch;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned GPIO_W     = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        wake_req, wake_ack, cmd_err;
  logic [3:0]  wake_tid;
  logic [15:0] gpio_out, dispatch_count;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_exec = 0;

  ca_dispatch_if ca_bus ();

  ca_dispatch #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GPIO_W     (GPIO_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ca             (ca_bus.slave),
    .wake_req       (wake_req),
    .wake_tid       (wake_tid),
    .wake_ack       (wake_ack),
    .gpio_out       (gpio_out),
    .cmd_err        (cmd_err),
    .dispatch_count (dispatch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] cmd);
    ca_bus.ca_match   = 1'b1;
    ca_bus.ca_command = cmd;
    step();
    ca_bus.ca_match   = 1'b0;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef CA_DISPATCH_STATS_EN
    return 32'(n_exec);
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    ca_bus.ca_match   = 1'b0;
    ca_bus.ca_command = '0;
    wake_ack          = 1'b0;
    #2 rstn = 1'b0;
    step(2);
    rstn = 1'b1;

    check("rst_block", 32'(ca_bus.ca_match_block), 32'h0);
    check("rst_wake_req", 32'(wake_req), 32'h0);
    check("rst_wake_tid", 32'(wake_tid), 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_err", 32'(cmd_err), 32'h0);
    check("rst_cnt", 32'(dispatch_count), 32'h0);

    // Single SET: visible exactly three cycles after the match cycle.
    send(32'h2000_00A5);
    step();
    check("set_early", 32'(gpio_out), 32'h0);
    step();
    n_exec = 1;
    check("set_lat3", 32'(gpio_out), 32'h00A5);
    check("set_cnt", 32'(dispatch_count), exp_cnt());

    // WAKE tid 3 with a SET queued behind it.
    send(32'h1300_0000);
    send(32'h2000_0100);
    step();
    for (int i = 0; i < 5; i++) begin
      check("wake_hold_req", 32'(wake_req), 32'h1);
      check("wake_hold_tid", 32'(wake_tid), 32'h3);
      check("wake_hold_gpio", 32'(gpio_out), 32'h00A5);
      step();
    end
    wake_ack = 1'b1;
    step();
    wake_ack = 1'b0;
    check("wake_drop", 32'(wake_req), 32'h0);
    step();
    check("wake_set_early", 32'(gpio_out), 32'h00A5);
    step();
    n_exec = 3;
    check("wake_set_after", 32'(gpio_out), 32'h01A5);
    check("wake_cnt", 32'(dispatch_count), exp_cnt());

    // Backpressure behind a stalled WAKE, then the WR/CLR/TGL sequence.
    send(32'h1500_0000);
    step(2);
    check("bp_wake_tid", 32'(wake_tid), 32'h5);
    send(32'h5000_FFFF);
    check("bp_block1", 32'(ca_bus.ca_match_block), 32'h0);
    send(32'h3000_00F0);
    check("bp_block2", 32'(ca_bus.ca_match_block), 32'h0);
    send(32'h4000_0001);
    check("bp_block3", 32'(ca_bus.ca_match_block), 32'h1);
    ca_bus.ca_match   = 1'b1;
    ca_bus.ca_command = 32'h4000_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_repeat_block", 32'(ca_bus.ca_match_block), 32'h1);
    end
    ca_bus.ca_match = 1'b0;
    wake_ack = 1'b1;
    step();
    wake_ack = 1'b0;
    step(8);
    n_exec = 7;
    check("seq_gpio", 32'(gpio_out), 32'hFF0E);
    check("seq_unblock", 32'(ca_bus.ca_match_block), 32'h0);
    check("seq_err", 32'(cmd_err), 32'h0);
    check("seq_cnt", 32'(dispatch_count), exp_cnt());

    // Illegal opcode: NOP behaviour plus sticky error.
    send(32'h9000_0000);
    step(2);
    n_exec = 8;
    check("ill_gpio", 32'(gpio_out), 32'hFF0E);
    check("ill_err", 32'(cmd_err), 32'h1);
    send(32'h2000_0000);
    step(2);
    n_exec = 9;
    check("ill_sticky", 32'(cmd_err), 32'h1);
    check("ill_cnt", 32'(dispatch_count), exp_cnt());

    // Reset during WAIT_ACK with two commands queued.
    send(32'h1700_0000);
    step(2);
    check("rw_tid", 32'(wake_tid), 32'h7);
    send(32'h5000_1234);
    send(32'h2000_0F00);
    rstn = 1'b0;
    #2;
    check("rw_async_req", 32'(wake_req), 32'h0);
    check("rw_async_tid", 32'(wake_tid), 32'h0);
    check("rw_async_gpio", 32'(gpio_out), 32'h0);
    check("rw_async_err", 32'(cmd_err), 32'h0);
    check("rw_async_block", 32'(ca_bus.ca_match_block), 32'h0);
    step();
    rstn = 1'b1;
    n_exec = 0;
    step(6);
    check("rw_after_gpio", 32'(gpio_out), 32'h0);
    check("rw_after_req", 32'(wake_req), 32'h0);
    check("rw_after_cnt", 32'(dispatch_count), exp_cnt());

    // Overflow: bypass backpressure to fill the FIFO, then push once more.
    send(32'h1200_0000);
    step(2);
    check("ovf_wake", 32'(wake_req), 32'h1);
    force dut.block_q = 1'b0;
    send(32'h5000_00AA);
    send(32'h2000_0100);
    send(32'h4000_0003);
    send(32'h2000_8000);
    check("ovf_full_noerr", 32'(cmd_err), 32'h0);
    send(32'h5000_FFFF);
    check("ovf_err", 32'(cmd_err), 32'h1);
    release dut.block_q;
    step();
    check("ovf_block", 32'(ca_bus.ca_match_block), 32'h1);
    wake_ack = 1'b1;
    step();
    wake_ack = 1'b0;
    step(12);
    n_exec = 5;
    check("ovf_gpio", 32'(gpio_out), 32'h81A9);
    check("ovf_err_sticky", 32'(cmd_err), 32'h1);
    check("ovf_unblock", 32'(ca_bus.ca_match_block), 32'h0);
    check("ovf_cnt", 32'(dispatch_count), exp_cnt());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
